// File: rtl/seg_scan_ctrl_if.sv
// Digit/segment bundle between BCD producer, scan controller and pins.
// master: drives BCD_3..BCD_0/LOAD; slave: drives SEG/AN/FRAME_TICK/UPDATED.
interface seg_scan_ctrl_if;
  logic [3:0] BCD_3;
  logic [3:0] BCD_2;
  logic [3:0] BCD_1;
  logic [3:0] BCD_0;
  logic       LOAD;
  logic [6:0] SEG;
  logic [3:0] AN;
  logic       FRAME_TICK;
  logic       UPDATED;

  modport master (
    output BCD_3, BCD_2, BCD_1, BCD_0, LOAD,
    input  SEG, AN, FRAME_TICK, UPDATED
  );

  modport slave (
    input  BCD_3, BCD_2, BCD_1, BCD_0, LOAD,
    output SEG, AN, FRAME_TICK, UPDATED
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// 4-digit common-anode 7-seg scanner, double-buffered BCD, guard blanking.
// Ports: CLK, RESETN (sync, active-low), bus (slave). Option: SEG_LZB_EN.
module seg_scan_ctrl #(
  parameter int CLK_DIV = 50000,
  parameter int GUARD   = 1
) (
  input logic          CLK,
  input logic          RESETN,
  seg_scan_ctrl_if.slave bus
);
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0]  cnt;
  logic [1:0]     idx;
  logic [3:0][3:0] act;
  logic [3:0][3:0] pend;
  logic           pend_v;
  logic [3:0]     an;
  logic [6:0]     seg;
  logic           frame_tick;
  logic           updated;

  logic [3:0]     dig;
  logic [31:0]    cnt32;
  logic           guard;
  logic           lzb;
  logic           slot_end;
  logic           frame_end;

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  assign dig       = act[idx];
  assign cnt32     = 32'(cnt);
  assign guard     = cnt32 < 32'(GUARD);
  assign slot_end  = cnt == LAST;
  assign frame_end = slot_end && (idx == 2'd3);

`ifdef SEG_LZB_EN
  // A digit is a leading zero when it and every digit left of it is 0.
  always_comb begin
    lzb = 1'b0;
    case (idx)
      2'd3: lzb = act[3] == 4'd0;
      2'd2: lzb = (act[3] == 4'd0) && (act[2] == 4'd0);
      2'd1: lzb = (act[3] == 4'd0) && (act[2] == 4'd0)
               && (act[1] == 4'd0);
      default: lzb = 1'b0;
    endcase
  end
`else
  assign lzb = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      cnt        <= '0;
      idx        <= 2'd0;
      act        <= {4{4'hF}};
      pend       <= {4{4'hF}};
      pend_v     <= 1'b0;
      an         <= 4'hF;
      seg        <= 7'h7F;
      frame_tick <= 1'b0;
      updated    <= 1'b0;
    end else begin
      cnt <= slot_end ? '0 : cnt + CW'(1);
      if (slot_end)
        idx <= idx + 2'd1;
      if (guard || lzb) begin
        an  <= 4'hF;
        seg <= 7'h7F;
      end else begin
        an  <= ~(4'b0001 << idx);
        seg <= decode(dig);
      end
      frame_tick <= frame_end;
      updated    <= frame_end && pend_v;
      if (frame_end && pend_v) begin
        act    <= pend;
        pend_v <= 1'b0;
      end
      // LOAD after the swap: same-edge LOAD lands in pend, kept valid.
      if (bus.LOAD) begin
        pend   <= {bus.BCD_3, bus.BCD_2, bus.BCD_1, bus.BCD_0};
        pend_v <= 1'b1;
      end
    end
  end

  assign bus.SEG        = seg;
  assign bus.AN         = an;
  assign bus.FRAME_TICK = frame_tick;
  assign bus.UPDATED    = updated;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized + directed bench for seg_scan_ctrl vs a cycle-position model.
// Model tracks cycles since reset; slot/digit derived by division.
module tb_seg_scan_ctrl;
  localparam int D = 4;
  localparam int G = 1;

  logic CLK = 1'b0;
  logic RESETN = 1'b0;

  seg_scan_ctrl_if bus();

  seg_scan_ctrl #(.CLK_DIV(D), .GUARD(G)) dut (
    .CLK(CLK),
    .RESETN(RESETN),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  logic [6:0] seg_tab [16];
  initial seg_tab = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'h7F, 7'h7F,
    7'h7F, 7'h7F, 7'h7F, 7'h7F};

  int p;
  int act [4];
  int pend [4];
  bit pv;
  logic [3:0] e_an;
  logic [6:0] e_seg;
  logic e_ft;
  logic e_up;
  bit armed = 0;
  int upd_cnt = 0;

  function automatic bit lead_zero(int i);
    bit z;
    z = 0;
`ifdef SEG_LZB_EN
    if (i > 0) begin
      z = 1;
      for (int k = i; k < 4; k++)
        if (act[k] != 0) z = 0;
    end
`endif
    return z;
  endfunction

  always @(posedge CLK) begin
    if (!RESETN) begin
      p = 0;
      pv = 0;
      for (int k = 0; k < 4; k++) begin
        act[k] = 15;
        pend[k] = 15;
      end
      e_an = 4'hF;
      e_seg = 7'h7F;
      e_ft = 0;
      e_up = 0;
    end else begin
      int c, d;
      bit fe;
      c = p % D;
      d = (p / D) % 4;
      if (c < G || lead_zero(d)) begin
        e_an = 4'hF;
        e_seg = 7'h7F;
      end else begin
        e_an = 4'hF;
        e_an[d] = 1'b0;
        e_seg = seg_tab[act[d]];
      end
      fe = (c == D - 1) && (d == 3);
      e_ft = fe;
      e_up = fe && pv;
      if (fe && pv) begin
        act = pend;
        pv = 0;
      end
      if (bus.LOAD) begin
        pend[3] = bus.BCD_3;
        pend[2] = bus.BCD_2;
        pend[1] = bus.BCD_1;
        pend[0] = bus.BCD_0;
        pv = 1;
      end
      p++;
    end
    armed = 1;
  end

  always @(negedge CLK) begin
    if (armed) begin
      chk("AN", 32'(bus.AN), 32'(e_an));
      chk("SEG", 32'(bus.SEG), 32'(e_seg));
      chk("FRAME_TICK", 32'(bus.FRAME_TICK), 32'(e_ft));
      chk("UPDATED", 32'(bus.UPDATED), 32'(e_up));
      if (bus.UPDATED === 1'b1) upd_cnt++;
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic load(int d3, int d2, int d1, int d0);
    bus.BCD_3 = 4'(d3);
    bus.BCD_2 = 4'(d2);
    bus.BCD_1 = 4'(d1);
    bus.BCD_0 = 4'(d0);
    bus.LOAD = 1'b1;
    @(negedge CLK);
    bus.LOAD = 1'b0;
  endtask

  task automatic to_pos(int m);
    for (int i = 0; i < 64 && (p % (4 * D)) != m; i++)
      @(negedge CLK);
    chk("to_pos", 32'(p % (4 * D)), 32'(m));
  endtask

  initial begin
    bus.LOAD = 1'b0;
    bus.BCD_3 = 4'd0;
    bus.BCD_2 = 4'd0;
    bus.BCD_1 = 4'd0;
    bus.BCD_0 = 4'd0;
    RESETN = 1'b0;
    cyc(3);
    RESETN = 1'b1;
    cyc(2);
    chk("first_en_an", 32'(bus.AN), 32'(4'b1110));
    chk("first_en_seg", 32'(bus.SEG), 32'(7'h7F));
    cyc(6);

    load(1, 2, 3, 4);
    cyc(40);

    to_pos(6);
    upd_cnt = 0;
    load(9, 9, 9, 9);
    cyc(32);
    chk("upd_once", 32'(upd_cnt), 32'd1);

    to_pos(2);
    load(5, 5, 5, 5);
    load(6, 6, 6, 6);
    cyc(36);

    to_pos(15);
    load(7, 7, 7, 7);
    cyc(36);

    load(1, 2, 3, 12);
    cyc(36);

    load(0, 0, 0, 7);
    cyc(36);

    to_pos(4);
    load(8, 8, 8, 8);
    to_pos(9);
    RESETN = 1'b0;
    cyc(2);
    RESETN = 1'b1;
    upd_cnt = 0;
    cyc(40);
    chk("no_upd_after_rst", 32'(upd_cnt), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      bus.LOAD = ($urandom_range(0, 11) == 0);
      if (bus.LOAD) begin
        bus.BCD_3 = 4'($urandom_range(0, 3) == 0 ? $urandom_range(0, 15)
                                                 : $urandom_range(0, 2));
        bus.BCD_2 = 4'($urandom_range(0, 3) == 0 ? $urandom_range(0, 15)
                                                 : $urandom_range(0, 9));
        bus.BCD_1 = 4'($urandom_range(0, 9));
        bus.BCD_0 = 4'($urandom_range(0, 15));
      end
      RESETN = ($urandom_range(0, 499) != 0);
      @(negedge CLK);
    end
    bus.LOAD = 1'b0;
    RESETN = 1'b1;
    cyc(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Drives a 4-digit common-anode 7-segment display from four BCD digits.
- Time-multiplexes one shared segment bus across four digit enables.
- Double-buffers the BCD inputs so the displayed value changes only at a frame boundary, which prevents tearing.
- Sits between the counter/timer logic that produces BCD digits and the board display pins.

Parameters:
- CLK_DIV, 50000: clock cycles per digit slot. Legal range is 2 or more.
- GUARD, 1: cycles at the start of each slot during which all digits are blanked (anti-ghosting). Legal range is 0 to CLK_DIV-1.

Ports:
- CLK  input  1  system clock
- RESETN  input  1  synchronous reset, active-low
- BCD_3  input  4  most significant digit
- BCD_2  input  4  digit 2
- BCD_1  input  4  digit 1
- BCD_0  input  4  least significant digit
- LOAD  input  1  one-cycle strobe; captures BCD_3..BCD_0 into the pending buffer
- SEG  output  7  segment drive, active-low, bit order {a,b,c,d,e,f,g}
- AN  output  4  digit enables, active-low; AN[0] is the rightmost digit, driven from BCD_0
- FRAME_TICK  output  1  one-cycle pulse when the digit-3 slot completes
- UPDATED  output  1  one-cycle pulse when the pending buffer has been copied into the active buffer

Behaviour:
- **Reset:** on a rising CLK edge with RESETN=0:
  - Counters: cnt=0, idx=0, pend_v=0.
  - Buffers: active and pending digits = 4'hF (blank).
  - Outputs: AN=4'b1111, SEG=7'b1111111, FRAME_TICK=0, UPDATED=0.
  - Reset mid-slot or mid-frame discards all state, including pending data.
- **Prescaler:**
  - cnt counts 0..CLK_DIV-1.
  - At cnt==CLK_DIV-1: cnt wraps to 0 and idx advances 0->1->2->3->0.
- **Segment decode** (active-low {a..g}):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - Values 10-15 decode to 1111111 (blank).
- **Output registers:** AN and SEG are registered and reflect the (idx, cnt) state of the previous cycle, i.e. 1-cycle latency.
  - If cnt<GUARD: AN=1111, SEG=1111111.
  - Otherwise: AN = all ones except bit idx = 0, and SEG = decode(active[idx]).
- **LOAD:**
  - pending <= BCD_3..BCD_0 and pend_v <= 1.
  - A LOAD while pend_v=1 overwrites pending; last write wins, no error.
- **Frame end** (cnt==CLK_DIV-1 and idx==3):
  - FRAME_TICK=1 on the next cycle.
  - If pend_v=1 (value before the edge): active <= pending, pend_v <= 0, and UPDATED=1 on the next cycle.
- **LOAD coinciding with frame end:**
  - The swap uses the pending contents from before the edge.
  - The new LOAD data lands in pending with pend_v=1 and is displayed from the following frame.
  - If pend_v was 0, no swap occurs this frame.
- **Invalid digits:** a blank (invalid) active digit still asserts its AN bit, with SEG=1111111.

Optional Feature:
- **Macro:** SEG_LZB_EN (leading-zero blanking).
- **With SEG_LZB_EN defined:**
  - Digit 3 is blanked if active_3==0.
  - Digit 2 is blanked if active_3 and active_2 are both 0.
  - Digit 1 is blanked if active_3, active_2 and active_1 are all 0.
  - Digit 0 is never blanked.
  - A blanked digit drives AN bit=1 and SEG=1111111 for its whole slot.
- **Without SEG_LZB_EN:** zeros are displayed normally.

Test Plan (CLK_DIV=4, GUARD=1):
- **Reset:** hold RESETN=0 for 3 cycles, then release -> AN=1111, SEG=1111111 throughout reset; first enabled output is AN=1110, SEG=1111111 (blank active digit) at cycle 2 after release.
- **Load and display:** LOAD with BCD=1,2,3,4 (digit 3 to digit 0) -> after the next FRAME_TICK and UPDATED, the slots show:
  - AN=1110 with SEG=1001100
  - AN=1101 with SEG=0000110
  - AN=1011 with SEG=0010010
  - AN=0111 with SEG=1001111
  - Each slot has 1 guard cycle at AN=1111 followed by 3 enabled cycles.
- **No tearing:** LOAD 9,9,9,9 mid-frame while displaying 1,2,3,4 -> the current frame still shows 1,2,3,4; 9s (SEG=0000100) appear only after the next FRAME_TICK; UPDATED pulses exactly once.
- **Overwrite and coincidence:**
  - Two LOADs (5555 then 6666) in one frame -> only 6 (SEG=0100000) is displayed.
  - LOAD asserted on the frame-end cycle -> displayed one frame later.
- **Invalid and leading zeros:**
  - BCD_0=4'hC -> digit 0 slot shows SEG=1111111 with AN=1110.
  - With SEG_LZB_EN and value 0,0,0,7 -> only AN=1110 is ever asserted, showing SEG=0001111.
- **Mid-frame reset:** assert RESETN=0 during the idx=2 slot with pend_v=1 -> after release, idx=0, the display is blank, and UPDATED never fires for the discarded data.
